// File: rtl/hex_scan_controller_pkg.sv
// Shared constants and helpers for the hex scan display controller.
// Segment encodings are active-high, bit 0 = a ... bit 6 = g.
package hex_scan_controller_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;

  // Small-scale timing used when simulating, so a frame is only a few cycles long.
  localparam int SIM_TICK_DIV     = 4;
  localparam int SIM_BLANK_CYCLES = 1;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/hex_scan_controller_hex_decoder.sv
// Hex nibble to 7-segment pattern (active-high, bit 0 = a ... bit 6 = g).
// Purely combinational; the scan controller registers its output.
module hex_scan_controller_hex_decoder
  import hex_scan_controller_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nibble)
      4'h0: o_seg = SEG_ZERO;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scan_controller.sv
// Digit-scanned 7-segment controller: one shared decoder, frame-synchronous
// value capture, per-slot anti-ghost blanking and leading-zero suppression.
module hex_scan_controller
  import hex_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    ack,
  output logic                    frame
);

  localparam int PW    = clog2(TICK_DIV);
  localparam int IDX_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);

  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    BLANK_LIM = PW'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_prescaler;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_en;
  logic                    r_ack;
  logic                    r_frame;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_blank;
  logic [3:0]            w_nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_suppress;
  logic [6:0]            w_seg_dec;
  logic [6:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_dig_next;

  assign w_slot_end  = (r_prescaler == PRE_LAST);
  assign w_frame_end = w_slot_end & (r_idx == IDX_LAST);
  assign w_blank     = (r_prescaler < BLANK_LIM);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
    assign w_nibble[gi] = r_shadow[4*gi +: 4];
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    w_suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (r_shadow[4*i +: 4] == 4'h0);
      w_suppress[i] = lz_en & all_zero;
    end
  end

  hex_scan_controller_hex_decoder u_hex_decoder (
    .i_nibble (w_nibble[r_idx]),
    .o_seg    (w_seg_dec)
  );

  always_comb begin
    w_dig_next = '0;
    if (!w_blank) begin
      w_dig_next[r_idx] = 1'b1;
    end
    w_seg_next = (w_blank | w_suppress[r_idx]) ? SEG_BLANK : w_seg_dec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prescaler <= '0;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_shadow    <= '0;
      r_seg       <= SEG_BLANK;
      r_dig_en    <= '0;
      r_ack       <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_frame <= 1'b0;
      r_seg    <= w_seg_next;
      r_dig_en <= w_dig_next;

      if (w_slot_end) begin
        r_prescaler <= '0;
        r_idx       <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_prescaler <= r_prescaler + 1'b1;
      end

      if (load) begin
        r_pending <= 1'b1;
      end

      // Capture only at the frame boundary; a load on this edge is consumed here.
      if (w_frame_end) begin
        r_frame <= 1'b1;
        if (r_pending | load) begin
          r_shadow  <= value;
          r_pending <= 1'b0;
          r_ack     <= 1'b1;
        end
      end
    end
  end

  assign seg    = r_seg;
  assign dig_en = r_dig_en;
  assign ack    = r_ack;
  assign frame  = r_frame;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Self-checking bench for hex_scan_controller at small simulation timing.
// Expected outputs come from a time-based model of the scan schedule.
module tb_hex_scan_controller;
  import hex_scan_controller_pkg::*;

  localparam int ND = 4;
  localparam int TD = SIM_TICK_DIV;
  localparam int BC = SIM_BLANK_CYCLES;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load  = 1'b0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        ack;
  logic        frame;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  hex_scan_controller #(
    .NUM_DIGITS   (ND),
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .value  (value),
    .load   (load),
    .lz_en  (lz_en),
    .seg    (seg),
    .dig_en (dig_en),
    .ack    (ack),
    .frame  (frame)
  );

  // Standard hex 7-segment glyphs, a = bit 0.
  logic [6:0] seg_rom [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: m_k edges have elapsed since reset, so the slot position and
  // the digit being scanned follow directly from division by TD and ND.
  int          m_k;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_ack;
  logic        exp_frame;

  always @(posedge clock) begin
    int   pos;
    int   digit;
    logic bl;
    logic sup;
    if (reset) begin
      m_k = 0; m_shadow = 16'h0; m_pending = 1'b0;
      exp_seg = 7'h00; exp_dig = 4'h0; exp_ack = 1'b0; exp_frame = 1'b0;
    end else begin
      pos   = m_k % TD;
      digit = (m_k / TD) % ND;
      bl    = (pos < BC);
      sup   = lz_en && (digit != 0) && ((m_shadow >> (4 * digit)) == 16'h0);
      exp_dig   = bl ? 4'h0 : 4'(1 << digit);
      exp_seg   = (bl || sup) ? 7'h00 : seg_rom[m_shadow[4*digit +: 4]];
      exp_frame = (pos == TD - 1) && (digit == ND - 1);
      exp_ack   = exp_frame && (m_pending || load);
      if (exp_ack) begin
        m_shadow = value; m_pending = 1'b0;
      end else if (load) begin
        m_pending = 1'b1;
      end
      m_k++;
    end
  end

  task automatic test_reset();
    int first;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_total++;
    if (seg !== 7'h00 || dig_en !== 4'h0 || ack !== 1'b0 || frame !== 1'b0)
      $display("FAIL reset_outputs seg=%h dig=%b ack=%b frame=%b want 00/0000/0/0", seg, dig_en, ack, frame);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (seg !== 7'h00 || dig_en !== 4'h0)
      $display("FAIL reset_blank_slot seg=%h dig=%b want 00/0000", seg, dig_en);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (seg !== 7'h3F || dig_en !== 4'b0001)
      $display("FAIL reset_first_digit seg=%h dig=%b want 3f/0001", seg, dig_en);
    else n_pass++;
    first = -1;
    for (int e = 3; e <= 40; e++) begin
      @(negedge clock);
      if (frame && first < 0) first = e;
    end
    n_total++;
    if (first != 16) $display("FAIL reset_first_frame edge=%0d want 16", first);
    else n_pass++;
  endtask

  task automatic test_load_pulse();
    int         acks;
    logic       found;
    logic [6:0] got [4];
    lz_en = 1'b0;
    value = 16'h8010;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (ack) acks++;
      n_total++;
      if ({seg, dig_en, ack, frame} !== {exp_seg, exp_dig, exp_ack, exp_frame})
        $display("FAIL pulse_model c=%0d seg=%h dig=%b ack=%b frame=%b want %h/%b/%b/%b",
                 c, seg, dig_en, ack, frame, exp_seg, exp_dig, exp_ack, exp_frame);
      else n_pass++;
    end
    n_total++;
    if (acks != 1) $display("FAIL pulse_ack_count got=%0d want 1", acks);
    else n_pass++;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (frame) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL pulse_frame_timeout got=0 want 1");
    else n_pass++;
    for (int d = 0; d < 4; d++) got[d] = 7'h55;
    for (int c = 0; c < TD * ND; c++) begin
      @(negedge clock);
      for (int d = 0; d < 4; d++) if (dig_en[d]) got[d] = seg;
    end
    n_total++;
    if (got[0] !== 7'h3F || got[1] !== 7'h06 || got[2] !== 7'h3F || got[3] !== 7'h7F)
      $display("FAIL pulse_digits got=%h %h %h %h want 3f 06 3f 7f", got[0], got[1], got[2], got[3]);
    else n_pass++;
  endtask

  task automatic test_load_hold();
    int         acks;
    int         frames;
    logic       found;
    logic [6:0] got [4];
    logic [3:0] seen;
    lz_en = 1'b1;
    value = 16'h0000;
    load  = 1'b1;
    acks = 0; frames = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (ack) acks++;
      if (frame) frames++;
      n_total++;
      if ({seg, dig_en, ack, frame} !== {exp_seg, exp_dig, exp_ack, exp_frame})
        $display("FAIL hold_model c=%0d seg=%h dig=%b ack=%b frame=%b want %h/%b/%b/%b",
                 c, seg, dig_en, ack, frame, exp_seg, exp_dig, exp_ack, exp_frame);
      else n_pass++;
    end
    load = 1'b0;
    n_total++;
    if (acks != frames || acks < 2) $display("FAIL hold_ack_per_frame acks=%0d want frames=%0d (>=2)", acks, frames);
    else n_pass++;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (frame) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL hold_frame_timeout got=0 want 1");
    else n_pass++;
    seen = 4'h0;
    for (int d = 0; d < 4; d++) got[d] = 7'h55;
    for (int c = 0; c < TD * ND; c++) begin
      @(negedge clock);
      for (int d = 0; d < 4; d++) if (dig_en[d]) begin got[d] = seg; seen[d] = 1'b1; end
    end
    n_total++;
    if (got[0] !== 7'h3F || got[1] !== 7'h00 || got[2] !== 7'h00 || got[3] !== 7'h00 || seen !== 4'hF)
      $display("FAIL hold_zero_lz got=%h %h %h %h en=%b want 3f 00 00 00 en=1111",
               got[0], got[1], got[2], got[3], seen);
    else n_pass++;
  endtask

  task automatic test_leading_zero();
    logic       found;
    logic [6:0] got [4];
    lz_en = 1'b1;
    value = 16'h00A0;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (ack) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL lz_ack_timeout got=0 want 1");
    else n_pass++;
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < 4; d++) got[d] = 7'h55;
      for (int c = 0; c < TD * ND; c++) begin
        @(negedge clock);
        for (int d = 0; d < 4; d++) if (dig_en[d]) got[d] = seg;
      end
      n_total++;
      if (pass == 0) begin
        if (got[0] !== 7'h3F || got[1] !== 7'h77 || got[2] !== 7'h00 || got[3] !== 7'h00)
          $display("FAIL lz_on_digits got=%h %h %h %h want 3f 77 00 00", got[0], got[1], got[2], got[3]);
        else n_pass++;
        lz_en = 1'b0;
      end else begin
        if (got[0] !== 7'h3F || got[1] !== 7'h77 || got[2] !== 7'h3F || got[3] !== 7'h3F)
          $display("FAIL lz_off_digits got=%h %h %h %h want 3f 77 3f 3f", got[0], got[1], got[2], got[3]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_blanking();
    int   run;
    logic seen_on;
    run = 0; seen_on = 1'b0;
    for (int c = 0; c < 240; c++) begin
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      lz_en = 1'($urandom_range(0, 1));
      load  = ($urandom_range(0, 7) == 0);
      @(negedge clock);
      n_total++;
      if ({seg, dig_en, ack, frame} !== {exp_seg, exp_dig, exp_ack, exp_frame})
        $display("FAIL rand_model c=%0d seg=%h dig=%b ack=%b frame=%b want %h/%b/%b/%b",
                 c, seg, dig_en, ack, frame, exp_seg, exp_dig, exp_ack, exp_frame);
      else n_pass++;
      n_total++;
      if ($countones(dig_en) > 1) $display("FAIL rand_onehot dig=%b want at most one bit", dig_en);
      else n_pass++;
      if (dig_en == 4'h0) run++;
      else begin
        if (seen_on && run > 0) begin
          n_total++;
          if (run != BC) $display("FAIL rand_blank_len got=%0d want %0d", run, BC);
          else n_pass++;
        end
        seen_on = 1'b1;
        run = 0;
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_pending();
    logic       found;
    int         acks;
    int         ack_edge;
    logic [6:0] got [4];
    lz_en = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (frame) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL rstp_frame_timeout got=0 want 1");
    else n_pass++;
    repeat (3) @(negedge clock);
    value = 16'h5A5A;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    acks = 0; ack_edge = -1;
    for (int d = 0; d < 4; d++) got[d] = 7'h55;
    for (int e = 1; e <= 40; e++) begin
      if (e == 20) begin value = 16'h1234; load = 1'b1; end
      if (e == 21) load = 1'b0;
      @(negedge clock);
      if (ack) begin acks++; if (ack_edge < 0) ack_edge = e; end
      if (e <= 16) for (int d = 0; d < 4; d++) if (dig_en[d]) got[d] = seg;
      n_total++;
      if ({seg, dig_en, ack, frame} !== {exp_seg, exp_dig, exp_ack, exp_frame})
        $display("FAIL rstp_model e=%0d seg=%h dig=%b ack=%b frame=%b want %h/%b/%b/%b",
                 e, seg, dig_en, ack, frame, exp_seg, exp_dig, exp_ack, exp_frame);
      else n_pass++;
    end
    n_total++;
    if (got[0] !== 7'h3F || got[1] !== 7'h3F || got[2] !== 7'h3F || got[3] !== 7'h3F)
      $display("FAIL rstp_shadow_cleared got=%h %h %h %h want 3f 3f 3f 3f", got[0], got[1], got[2], got[3]);
    else n_pass++;
    n_total++;
    if (acks != 1 || ack_edge != 32)
      $display("FAIL rstp_ack_timing acks=%0d edge=%0d want 1 at edge 32", acks, ack_edge);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_pulse();
    test_load_hold();
    test_leading_zero();
    test_random_blanking();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hex_scan_controller.md
Name: hex_scan_controller

Overview:
- Time-multiplexes NUM_DIGITS 4-bit hex digits through one shared hex_decoder onto a common-segment, digit-scanned 7-segment display.
- Owns the slot prescaler, digit scan counter, frame-synchronous load of new display values, anti-ghosting blanking and leading-zero suppression.
- Sits between the datapath that produces values (counters, ALU results) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digits; legal range 1..8.
- TICK_DIV, 50000, clock cycles per digit slot; must be >= BLANK_CYCLES+1 and >= 2.
- BLANK_CYCLES, 2, cycles at the start of each slot with all digit enables off; 0 disables blanking.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- value  in  4*NUM_DIGITS  digits to display; nibble i drives digit i; digit 0 is least significant.
- load  in  1  request to update the display; level or pulse.
- lz_en  in  1  leading-zero suppression enable; sampled every cycle.
- seg  out  7  segment pattern from hex_decoder; active-high, 1 = segment lit; bit 0 = a ... bit 6 = g.
- dig_en  out  NUM_DIGITS  one-hot digit enable; active-high.
- ack  out  1  one-cycle pulse when value has been captured.
- frame  out  1  one-cycle pulse on each scan wrap.

Behaviour:
- Reset values:
  - prescaler 0, digit index idx 0, pending 0, shadow 0.
  - seg 7'h00, dig_en 0, ack 0, frame 0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - On the edge where prescaler == TICK_DIV-1 (slot end), idx advances, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary is the slot end with idx == NUM_DIGITS-1.
  - frame is registered high for the cycle after that edge.
- Load:
  - Any cycle with load=1 sets pending.
  - Capture happens on the frame-boundary edge if (pending | load): shadow <= value sampled at that edge, pending <= 0, and ack is registered high for the following cycle.
  - Value is never captured mid-frame, so there is no tearing.
  - load asserted on the capture edge itself is consumed by that capture; it does not leave pending set.
  - Repeated loads within one frame produce exactly one capture and one ack.
- Output selection, computed from the current prescaler, idx and shadow, then registered (1-cycle latency, seg and dig_en aligned):
  - blank = (prescaler < BLANK_CYCLES).
  - Digit i is suppressed when lz_en=1, i != 0, and shadow nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is always shown.
  - dig_en = blank ? 0 : one-hot(idx).
  - seg = (blank | suppressed(idx)) ? 7'h00 : hex_decoder(shadow nibble idx).
- Reset mid-frame: all state returns to reset values on the next edge, and any pending load is discarded. The first slot after reset shows digit 0 of shadow=0, i.e. seg 7'h3F once blanking ends.
- NUM_DIGITS=1: idx stays 0, and every slot end is a frame boundary.
- Widths:
  - prescaler is clog2(TICK_DIV) bits.
  - idx is clog2(NUM_DIGITS) bits, minimum 1.
  - No arithmetic overflow is possible; the wraps are explicit compares.

Decomposition:
- Shared package holds:
  - segment constants: SEG_BLANK=7'h00, SEG_ZERO=7'h3F;
  - the clog2 helper function;
  - simulation overrides TICK_DIV=4, BLANK_CYCLES=1.
- Exactly one sub-module: the existing hex_decoder, instantiated once on the muxed nibble. It is not duplicated per digit.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, BLANK_CYCLES=1):
- Reset release:
  - seg=7'h00 and dig_en=0 for 2 cycles.
  - Then dig_en=4'b0001 and seg=7'h3F.
  - frame first pulses 16 cycles after reset release.
- Pulse load with value=16'h8010 mid-frame:
  - Display is unchanged until the frame boundary.
  - Then ack pulses once.
  - Next frame shows digit0 7'h3F, digit1 7'h06, digit2 7'h3F, digit3 7'h7F.
- Hold load high for 40 cycles:
  - One ack per frame boundary, no others.
  - Loading value=16'h0000 with lz_en=1 shows only digit 0 (7'h3F); digits 1-3 show seg=7'h00 while their dig_en is still asserted.
- Leading zeros: value=16'h00A0 with lz_en=1:
  - digits 3 and 2 are blank;
  - digit1 shows 7'h77 (the hex_decoder pattern for A);
  - digit0 shows 7'h3F (interior zero kept).
  - With lz_en=0, all four digits are shown.
- Blanking check: for every slot, dig_en=0 for exactly 1 cycle, and dig_en is never multi-hot.
- Reset asserted with pending=1 mid-frame:
  - No ack follows.
  - shadow=0 after reset.
  - A subsequent load is captured only at the first post-reset frame boundary.
